shift_seq: RTL and testbench

//   Multi-cycle sequencer for RV32 SLL/SRL/SRA using a narrow shifter (at most STEP bits per cycle) instead of a full barrel shifter.

---
 rtl/shift_seq.sv | 144 ++++++++++++++
 tb/tb_shift_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle RV32 SLL/SRL/SRA sequencer built on a narrow shifter.
// Moves the operand at most STEP bits per cycle. It accepts one op at a time from
// issue and holds the result until writeback takes it.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               abort any in-flight op and drop its result
//   req_valid_i/ready_o   request handshake (ready only in IDLE)
//   funct3_i, funct7_i    001 = SLL; 101 = SRL, or SRA when funct7_i is set
//   op1_i, op2_i          value to shift, shift amount (op2_i[4:0] only)
//   res_valid_o/ready_i   result handshake
//   res_o                 shifted result, qualified by res_valid_o
//   busy_o                sequencer not in IDLE
module shift_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  // Remaining-count width; one bit wider than a shamt so STEP=32 fits.
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {M_SLL, M_SRL, M_SRA} mode_e;

  state_e          state_q, state_d;
  mode_e           mode_q, mode_in;
  logic [XLEN-1:0] val_q, val_shift;
  logic [CW-1:0]   rem_q, rem_in, rem_nxt, k_c;
  logic            ready_d, valid_d, busy_d;
  logic            accept_c, load_res_c;
  logic            unused_op2;

  assign unused_op2 = ^op2_i[XLEN-1:5];
  assign accept_c   = req_valid_i && req_ready_o;

  // Decode an incoming request; unsupported funct3 becomes a zero-length shift.
  always_comb begin
    mode_in = M_SLL;
    rem_in  = '0;
    case (funct3_i)
      3'b001: begin
        mode_in = M_SLL;
        rem_in  = {1'b0, op2_i[4:0]};
      end
      3'b101: begin
        mode_in = funct7_i ? M_SRA : M_SRL;
        rem_in  = {1'b0, op2_i[4:0]};
      end
      default: begin
        mode_in = M_SLL;
        rem_in  = '0;
      end
    endcase
  end

  // Narrow shift step: move min(STEP, rem) bits this cycle.
  always_comb begin
    k_c     = (rem_q < CW'(STEP)) ? rem_q : CW'(STEP);
    rem_nxt = rem_q - k_c;
    case (mode_q)
      M_SRL:   val_shift = val_q >> k_c;
      M_SRA:   val_shift = $signed(val_q) >>> k_c;
      default: val_shift = val_q << k_c;
    endcase
  end

  // State register plus registered handshake/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_o <= ready_d;
      res_valid_o <= valid_d;
      busy_o      <= busy_d;
    end
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = (rem_in != '0) ? BUSY : DONE;
      BUSY: if (rem_nxt == '0) state_d = DONE;
      DONE: if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // Output decode of the upcoming state, registered above.
  always_comb begin
    ready_d    = (state_d == IDLE);
    valid_d    = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    load_res_c = (state_q != DONE) && (state_d == DONE);
  end

  // Datapath: operand/count registers and the held result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      val_q  <= '0;
      rem_q  <= '0;
      mode_q <= M_SLL;
      res_o  <= '0;
    end else if (flush_i) begin
      rem_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            val_q  <= op1_i;
            rem_q  <= rem_in;
            mode_q <= mode_in;
          end
        end
        BUSY: begin
          val_q <= val_shift;
          rem_q <= rem_nxt;
        end
        default: ;
      endcase
      // Capture the result only on entry to DONE so res_o holds otherwise.
      if (load_res_c) res_o <= (state_q == IDLE) ? op1_i : val_shift;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: three instances (STEP 1, 4, 32) share request
// stimulus. Expected results are queued at issue; a monitor checks each result
// value and its first-valid cycle.
module tb_shift_seq;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NI   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, req_valid, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op1, op2;
  logic [NI-1:0]   req_ready, res_valid, res_ready, busy;
  logic [XLEN-1:0] res [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shift_seq #(.XLEN(XLEN), .STEP(g == 0 ? 1 : (g == 1 ? 4 : 32))) u_dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready[g]),
      .funct3_i(funct3), .funct7_i(funct7), .op1_i(op1), .op2_i(op2),
      .res_valid_o(res_valid[g]), .res_ready_i(res_ready[g]),
      .res_o(res[g]), .busy_o(busy[g]));
  end

  typedef struct {
    logic [31:0] res;
    int          base;
    int          sh;
  } exp_t;

  exp_t exp_q[$];
  int   rd[NI];
  bit   seen[NI];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int step_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 32);
  endfunction

  function automatic logic [31:0] ref_op(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'b001:  return a << b[4:0];
      3'b101:  return f7 ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      default: return a;
    endcase
  endfunction

  task automatic check(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h (t=%0t)", name, inst, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: check each result once, when res_valid first rises.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!res_valid[i]) begin
        seen[i] = 1'b0;
      end else if (!seen[i]) begin
        seen[i] = 1'b1;
        if (rd[i] >= exp_q.size()) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid inst%0d got res %h want no result", i, res[i]);
        end else begin
          exp_t e;
          e = exp_q[rd[i]];
          rd[i]++;
          check("result", i, res[i], e.res);
          check("latency", i, 32'(cyc), 32'(e.base + 1 + (e.sh + step_of(i) - 1) / step_of(i)));
        end
      end
    end
  end

  task automatic wait_all_ready();
    int n = 0;
    while (req_ready != '1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        fail_now("timeout_ready");
        return;
      end
    end
  endtask

  task automatic wait_all_valid();
    int n = 0;
    while (res_valid != '1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        fail_now("timeout_valid");
        return;
      end
    end
  endtask

  task automatic issue(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b,
                       logic [31:0] expv, int sh_eff);
    wait_all_ready();
    funct3    = f3;
    funct7    = f7;
    op1       = a;
    op2       = b;
    req_valid = 1'b1;
    exp_q.push_back('{res: expv, base: cyc, sh: sh_eff});
    @(negedge clk);
    req_valid = 1'b0;
    op1       = $urandom;
    op2       = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (req_ready != '1 || rd[0] != exp_q.size() || rd[1] != exp_q.size() ||
           rd[2] != exp_q.size()) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        fail_now("timeout_drain");
        return;
      end
    end
  endtask

  task automatic drop_pending();
    for (int i = 0; i < NI; i++) rd[i] = exp_q.size();
  endtask

  task automatic check_idle_outputs(string name, logic [31:0] res_exp, bit check_res);
    for (int i = 0; i < NI; i++) begin
      check({name, "_ready"}, i, 32'(req_ready[i]), 32'd1);
      check({name, "_valid"}, i, 32'(res_valid[i]), 32'd0);
      check({name, "_busy"}, i, 32'(busy[i]), 32'd0);
      if (check_res) check({name, "_res"}, i, res[i], res_exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      rd[i]   = 0;
      seen[i] = 1'b0;
    end
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
    funct3 = 3'b000; funct7 = 1'b0; op1 = '0; op2 = '0;
    res_ready = '1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset", 32'h0, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed results.
    issue(3'b001, 1'b0, 32'h0000_0001, 32'd31,        32'h8000_0000, 31);
    issue(3'b101, 1'b1, 32'h8000_00F0, 32'd4,         32'hF800_000F, 4);
    issue(3'b101, 1'b0, 32'h8000_00F0, 32'd4,         32'h0800_000F, 4);
    issue(3'b101, 1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 0);
    issue(3'b001, 1'b1, 32'h0000_0003, 32'h0000_0025, 32'h0000_0060, 5);
    issue(3'b101, 1'b1, 32'h7000_0000, 32'd31,        32'h0000_0000, 31);
    issue(3'b101, 1'b1, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 31);
    issue(3'b000, 1'b0, 32'h1234_5678, 32'd7,         32'h1234_5678, 0);
    issue(3'b011, 1'b1, 32'hCAFE_0000, 32'd3,         32'hCAFE_0000, 0);
    drain();

    // Backpressure: result held for 5 cycles, new requests ignored.
    res_ready = '0;
    issue(3'b001, 1'b0, 32'h0000_00FF, 32'd8, 32'h0000_FF00, 8);
    wait_all_valid();
    funct3 = 3'b001; funct7 = 1'b0; op1 = 32'hFFFF_FFFF; op2 = 32'd1;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check("bp_res", i, res[i], 32'h0000_FF00);
        check("bp_valid", i, 32'(res_valid[i]), 32'd1);
        check("bp_ready", i, 32'(req_ready[i]), 32'd0);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    res_ready = '1;
    @(negedge clk);
    repeat (40) @(negedge clk);
    check_idle_outputs("bp_after", 32'h0, 1'b0);

    // Flush mid-BUSY: no result may appear.
    wait_all_ready();
    funct3 = 3'b001; funct7 = 1'b0; op1 = 32'h0000_0001; op2 = 32'd20;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle_outputs("flush", 32'h0, 1'b0);
    repeat (30) @(negedge clk);

    // Request presented together with flush in IDLE is not accepted.
    funct3 = 3'b001; op1 = 32'h0000_0005; op2 = 32'd2;
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check_idle_outputs("flush_idle", 32'h0, 1'b0);
    issue(3'b001, 1'b0, 32'h0000_0003, 32'd1, 32'h0000_0006, 1);
    drain();

    // Reset while holding a result in DONE.
    res_ready = '0;
    issue(3'b101, 1'b1, 32'hF000_0000, 32'd4, 32'hFF00_0000, 4);
    wait_all_valid();
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_done", 32'h0, 1'b1);
    rst = 1'b0;
    res_ready = '1;
    @(negedge clk);

    // Sweep all modes and shift amounts against the reference operators.
    for (int m = 0; m < 3; m++) begin
      for (int sh = 0; sh < 32; sh++) begin
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b;
        f3 = (m == 0) ? 3'b001 : 3'b101;
        f7 = (m == 0) ? 1'($urandom) : ((m == 2) ? 1'b1 : 1'b0);
        a  = $urandom;
        if (sh[0]) a[31] = 1'b1;
        b  = ($urandom & 32'hFFFF_FFE0) | 32'(sh);
        issue(f3, f7, a, b, ref_op(f3, f7, a, b), sh);
      end
    end
    drain();

    for (int i = 0; i < NI; i++)
      check("pending", i, 32'(rd[i]), 32'(exp_q.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
